// File: rtl/resource_regulator.sv
// resource_regulator: closed-loop driver for a saturating resource counter.
// Steers the counter's value toward a target with rate-limited inc/dec
// pulses. It uses fast steps when far from the target and single steps when
// near it. It also forwards a rising-edge "set" request as one setval pulse.
module resource_regulator #(
    parameter int N           = 8,
    parameter int FAST_STEP   = 3,
    parameter int FAST_THRESH = 8,
    parameter int DEADBAND    = 0,
    parameter int PERIOD_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [N-1:0]        target,
    input  logic [N-1:0]        value,
    input  logic [PERIOD_W-1:0] period,
    input  logic                force_set,
    output logic                inc,
    output logic                dec,
    output logic                fast,
    output logic                setval,
    output logic                busy,
    output logic                at_target
);

    typedef enum logic [1:0] {IDLE, STEP, SET, HOLD} state_t;

    localparam logic [N-1:0] DEADBAND_N    = N'(DEADBAND);
    localparam logic [N-1:0] FAST_THRESH_N = N'(FAST_THRESH);

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] timer;
    logic                set_pending;
    logic                force_set_q;
    logic                force_set_rise;
    logic                up;
    logic [N-1:0]        err;
    logic                inc_q;
    logic                dec_q;
    logic                fast_q;

    // Unsigned distance to the target; subtracting the smaller operand from
    // the larger one means the difference can never wrap.
    always_comb begin
        up  = (target > value);
        err = up ? (target - value) : (value - target);
    end

    assign force_set_rise = force_set & ~force_set_q;

    // State register; reset lands in IDLE so every command output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decision: a pending set request beats regulation and aborts a hold.
    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (set_pending)                         state_nxt = SET;
                else if (enable && (err > DEADBAND_N))   state_nxt = STEP;
            end
            STEP:    state_nxt = HOLD;
            SET:     state_nxt = HOLD;
            HOLD: begin
                if (set_pending)       state_nxt = SET;
                else if (timer == '0)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pacing timer, set-request capture, step direction latch and at_target flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            set_pending <= 1'b0;
            force_set_q <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            fast_q      <= 1'b0;
            at_target   <= 1'b0;
        end else begin
            force_set_q <= force_set;
            at_target   <= (err <= DEADBAND_N);

            // A fresh edge wins over clearing, so an edge seen while entering
            // or sitting in SET is serviced again afterwards.
            if (force_set_rise)          set_pending <= 1'b1;
            else if (state_nxt == SET)   set_pending <= 1'b0;

            if (state == STEP || state == SET)      timer <= period;
            else if (state == HOLD && timer != '0)  timer <= timer - 1'b1;

            // Freeze direction and step size at the decision point so the
            // STEP pulse is not disturbed by inputs moving during that cycle.
            if (state == IDLE && state_nxt == STEP) begin
                inc_q  <= up;
                dec_q  <= ~up;
                fast_q <= (err >= FAST_THRESH_N);
            end
        end
    end

    // Command outputs decoded from state; each command lives for exactly one cycle.
    always_comb begin
        inc    = 1'b0;
        dec    = 1'b0;
        fast   = 1'b0;
        setval = 1'b0;
        case (state)
            STEP: begin
                inc  = inc_q;
                dec  = dec_q;
                fast = fast_q;
            end
            SET:     setval = 1'b1;
            default: ;
        endcase
        busy = (state != IDLE);
    end

    // A fast step must never be able to jump past the target.
    assert property (@(posedge clk) FAST_THRESH >= FAST_STEP);
    // Commands are mutually exclusive single-cycle pulses.
    assert property (@(posedge clk) disable iff (rst) !(inc && dec));
    assert property (@(posedge clk) disable iff (rst) !(setval && (inc || dec)));
    assert property (@(posedge clk) disable iff (rst) fast |-> (inc || dec));
    assert property (@(posedge clk) disable iff (rst) (inc || dec || setval) |=> !(inc || dec || setval));

endmodule

// File: tb/tb_resource_regulator.sv
// Testbench for resource_regulator: two instances (DEADBAND 0 and 2), each
// closed around a behavioural saturating counter. Observed command pulses
// are collected by a monitor and compared against expected pulses queued
// by each test.
module tb_resource_regulator;

    localparam int    FAST_STEP = 3;
    localparam logic [7:0] DEF_VAL = 8'd2;

    typedef struct {
        int   cyc;
        logic inc;
        logic dec;
        logic fast;
        logic setval;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Instance 0: DEADBAND = 0
    logic       enable0 = 1'b0;
    logic [7:0] target0 = 8'd2;
    logic [3:0] period0 = 4'd0;
    logic       force_set0 = 1'b0;
    logic       inc0, dec0, fast0, setval0, busy0, at_target0;
    logic [7:0] val0 = 8'd2;
    logic       ld0 = 1'b0;
    logic [7:0] ld_val0 = 8'd0;

    // Instance 1: DEADBAND = 2
    logic       enable1 = 1'b0;
    logic [7:0] target1 = 8'd2;
    logic [3:0] period1 = 4'd0;
    logic       force_set1 = 1'b0;
    logic       inc1, dec1, fast1, setval1, busy1, at_target1;
    logic [7:0] val1 = 8'd2;
    logic       ld1 = 1'b0;
    logic [7:0] ld_val1 = 8'd0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int inv_err  = 0;

    pulse_t obs0[$];
    pulse_t obs1[$];
    pulse_t exp_q[$];

    resource_regulator #(.N(8), .FAST_STEP(3), .FAST_THRESH(8), .DEADBAND(0), .PERIOD_W(4)) dut0 (
        .clk(clk), .rst(rst), .enable(enable0), .target(target0), .value(val0),
        .period(period0), .force_set(force_set0), .inc(inc0), .dec(dec0),
        .fast(fast0), .setval(setval0), .busy(busy0), .at_target(at_target0)
    );

    resource_regulator #(.N(8), .FAST_STEP(3), .FAST_THRESH(8), .DEADBAND(2), .PERIOD_W(4)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .target(target1), .value(val1),
        .period(period1), .force_set(force_set1), .inc(inc1), .dec(dec1),
        .fast(fast1), .setval(setval1), .busy(busy1), .at_target(at_target1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sat_step(logic [7:0] v, logic up, logic f);
        int s;
        int r;
        s = f ? FAST_STEP : 1;
        r = up ? int'(v) + s : int'(v) - s;
        if (r > 255) r = 255;
        if (r < 0)   r = 0;
        return 8'(r);
    endfunction

    // Saturating resource counters fed by the regulator commands.
    always @(posedge clk) begin
        if (ld0)                val0 <= ld_val0;
        else if (setval0)       val0 <= DEF_VAL;
        else if (inc0 || dec0)  val0 <= sat_step(val0, inc0, fast0);

        if (ld1)                val1 <= ld_val1;
        else if (setval1)       val1 <= DEF_VAL;
        else if (inc1 || dec1)  val1 <= sat_step(val1, inc1, fast1);
    end

    // Pulse monitor and output-invariant watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (inc0 || dec0 || setval0) obs0.push_back('{cyc, inc0, dec0, fast0, setval0});
        if (inc1 || dec1 || setval1) obs1.push_back('{cyc, inc1, dec1, fast1, setval1});
        if ((inc0 && dec0) || (setval0 && (inc0 || dec0)) || (fast0 && !(inc0 || dec0))) inv_err <= inv_err + 1;
        if ((inc1 && dec1) || (setval1 && (inc1 || dec1)) || (fast1 && !(inc1 || dec1))) inv_err <= inv_err + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load0(input logic [7:0] v);
        ld_val0 = v;
        ld0 = 1'b1;
        tick();
        ld0 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic found;
        tick(); tick(); tick();
        checks++;
        if ({inc0, dec0, fast0, setval0, busy0, at_target0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b required 000000", {inc0, dec0, fast0, setval0, busy0, at_target0});
        end
        rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({at_target0, at_target1} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_at_target got %b required 11", {at_target0, at_target1});
        end
        // Start a step and reset while inc is high.
        target0 = 8'd20;
        enable0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (inc0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_step_start got no inc required inc within 10 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({inc0, busy0, at_target0, at_target1} !== 4'b0) begin
            failures++;
            $display("FAIL reset_abort got inc/busy/at0/at1=%b required 0000", {inc0, busy0, at_target0, at_target1});
        end
        tick();
        checks++;
        if (val0 !== 8'd2) begin
            failures++;
            $display("FAIL reset_abort_value got %0d required 2", val0);
        end
        target0 = 8'd2;
        rst = 1'b0;
        obs0.delete();
        obs1.delete();
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (obs0.size() != 0 || busy0 !== 1'b0 || at_target0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle got pulses=%0d busy=%b at=%b required 0 0 1", obs0.size(), busy0, at_target0);
        end
        enable0 = 1'b0;
        tick();
    endtask

    // Shared body for a monotone ramp with fixed pulse spacing.
    task automatic test_ramp(input string name, input logic [7:0] start, input logic [7:0] tgt,
                             input logic [3:0] per, input int run_cycles);
        pulse_t e;
        pulse_t o;
        int     prev;
        int     idx;
        enable0 = 1'b0;
        period0 = per;
        load0(start);
        obs0.delete();
        exp_q.delete();
        begin
            logic [7:0] m;
            logic       up;
            m  = start;
            up = (tgt > start);
            while (m != tgt) begin
                int d;
                logic f;
                d = up ? int'(tgt) - int'(m) : int'(m) - int'(tgt);
                f = (d >= 8);
                exp_q.push_back('{0, up, !up, f, 1'b0});
                m = sat_step(m, up, f);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_plan got 0 expected pulses required at least 1", name);
        end
        target0 = tgt;
        enable0 = 1'b1;
        for (int i = 0; i < run_cycles; i++) tick();
        checks++;
        if (obs0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count got %0d pulses required %0d", name, obs0.size(), exp_q.size());
        end
        prev = 0;
        idx  = 0;
        while (exp_q.size() > 0 && obs0.size() > 0) begin
            e = exp_q.pop_front();
            o = obs0.pop_front();
            checks++;
            if ({o.inc, o.dec, o.fast, o.setval} !== {e.inc, e.dec, e.fast, e.setval}) begin
                failures++;
                $display("FAIL %s_pulse[%0d] got inc/dec/fast/set=%b required %b", name, idx,
                         {o.inc, o.dec, o.fast, o.setval}, {e.inc, e.dec, e.fast, e.setval});
            end
            if (idx > 0) begin
                checks++;
                if (o.cyc - prev != int'(per) + 3) begin
                    failures++;
                    $display("FAIL %s_spacing[%0d] got %0d cycles required %0d", name, idx, o.cyc - prev, int'(per) + 3);
                end
            end
            prev = o.cyc;
            idx++;
        end
        checks++;
        if (val0 !== tgt || at_target0 !== 1'b1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL %s_final got value=%0d at=%b busy=%b required %0d 1 0", name, val0, at_target0, busy0, tgt);
        end
        enable0 = 1'b0;
        obs0.delete();
        exp_q.delete();
    endtask

    task automatic test_fast_slow_up();
        test_ramp("up", 8'd2, 8'd20, 4'd0, 60);
    endtask

    task automatic test_down_saturation();
        test_ramp("down", 8'd255, 8'd0, 4'd2, 500);
    endtask

    task automatic test_force_set_hold();
        pulse_t o;
        pulse_t e;
        logic   found;
        int     drv;
        int     idx;
        enable0 = 1'b0;
        period0 = 4'd5;
        load0(8'd10);
        obs0.delete();
        exp_q.delete();
        // 10 -> 13 fast, set to 2, then 7 fast (2 -> 23) and 7 single (23 -> 30).
        exp_q.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0});
        exp_q.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 7; i++) exp_q.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 7; i++) exp_q.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0});
        target0 = 8'd30;
        enable0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (obs0.size() > 0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL fset_first_step got none required inc within 10 cycles");
        end
        tick();
        force_set0 = 1'b1;
        drv = cyc;
        tick();
        force_set0 = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        checks++;
        if (obs0.size() != exp_q.size()) begin
            failures++;
            $display("FAIL fset_count got %0d pulses required %0d", obs0.size(), exp_q.size());
        end
        idx = 0;
        while (exp_q.size() > 0 && obs0.size() > 0) begin
            e = exp_q.pop_front();
            o = obs0.pop_front();
            checks++;
            if ({o.inc, o.dec, o.fast, o.setval} !== {e.inc, e.dec, e.fast, e.setval}) begin
                failures++;
                $display("FAIL fset_pulse[%0d] got inc/dec/fast/set=%b required %b", idx,
                         {o.inc, o.dec, o.fast, o.setval}, {e.inc, e.dec, e.fast, e.setval});
            end
            if (idx == 1) begin
                checks++;
                if (o.cyc != drv + 2) begin
                    failures++;
                    $display("FAIL fset_timing got cycle %0d required %0d", o.cyc, drv + 2);
                end
            end
            idx++;
        end
        checks++;
        if (val0 !== 8'd30 || at_target0 !== 1'b1) begin
            failures++;
            $display("FAIL fset_final got value=%0d at=%b required 30 1", val0, at_target0);
        end
        enable0 = 1'b0;
        obs0.delete();
        exp_q.delete();
    endtask

    task automatic test_enable_retarget();
        pulse_t o;
        pulse_t e;
        logic   found;
        int     en_cyc;
        enable0 = 1'b0;
        period0 = 4'd3;
        target0 = 8'd20;
        load0(8'd10);
        obs0.delete();
        exp_q.delete();
        for (int i = 0; i < 50; i++) tick();
        checks++;
        if (obs0.size() != 0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL enable_gate got pulses=%0d busy=%b required 0 0", obs0.size(), busy0);
        end
        exp_q.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0});
        exp_q.push_back('{0, 1'b0, 1'b1, 1'b1, 1'b0});
        enable0 = 1'b1;
        en_cyc = cyc;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (obs0.size() > 0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL enable_first got none required pulse within 10 cycles");
        end else begin
            o = obs0.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.cyc != en_cyc + 1) begin
                failures++;
                $display("FAIL enable_latency got cycle %0d required %0d", o.cyc, en_cyc + 1);
            end
            checks++;
            if ({o.inc, o.dec, o.fast, o.setval} !== {e.inc, e.dec, e.fast, e.setval}) begin
                failures++;
                $display("FAIL enable_first_pulse got %b required %b", {o.inc, o.dec, o.fast, o.setval}, {e.inc, e.dec, e.fast, e.setval});
            end
        end
        // Retarget below the current value while holding.
        tick();
        target0 = 8'd5;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (obs0.size() > 0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL retarget got none required dec within 20 cycles");
        end else begin
            o = obs0.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({o.inc, o.dec, o.fast, o.setval} !== {e.inc, e.dec, e.fast, e.setval}) begin
                failures++;
                $display("FAIL retarget_pulse got %b required %b", {o.inc, o.dec, o.fast, o.setval}, {e.inc, e.dec, e.fast, e.setval});
            end
        end
        enable0 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        obs0.delete();
        exp_q.delete();
    endtask

    task automatic test_deadband();
        pulse_t o;
        pulse_t e;
        enable1 = 1'b0;
        period1 = 4'd0;
        ld_val1 = 8'd18;
        ld1 = 1'b1;
        tick();
        ld1 = 1'b0;
        target1 = 8'd20;
        tick();
        obs1.delete();
        exp_q.delete();
        enable1 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (obs1.size() != 0 || at_target1 !== 1'b1) begin
            failures++;
            $display("FAIL deadband_hold got pulses=%0d at=%b required 0 1", obs1.size(), at_target1);
        end
        exp_q.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0});
        target1 = 8'd21;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (obs1.size() != exp_q.size()) begin
            failures++;
            $display("FAIL deadband_count got %0d pulses required %0d", obs1.size(), exp_q.size());
        end
        if (obs1.size() > 0 && exp_q.size() > 0) begin
            o = obs1.pop_front();
            e = exp_q.pop_front();
            checks++;
            if ({o.inc, o.dec, o.fast, o.setval} !== {e.inc, e.dec, e.fast, e.setval}) begin
                failures++;
                $display("FAIL deadband_pulse got %b required %b", {o.inc, o.dec, o.fast, o.setval}, {e.inc, e.dec, e.fast, e.setval});
            end
        end
        checks++;
        if (val1 !== 8'd19 || at_target1 !== 1'b1) begin
            failures++;
            $display("FAIL deadband_final got value=%0d at=%b required 19 1", val1, at_target1);
        end
        enable1 = 1'b0;
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_err != 0) begin
            failures++;
            $display("FAIL output_invariants got %0d violations required 0", inv_err);
        end
    endtask

    initial begin
        test_reset();
        test_fast_slow_up();
        test_down_saturation();
        test_force_set_hold();
        test_enable_retarget();
        test_deadband();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
